cla_accumulator_stage: RTL and testbench

//   Packet accumulator that drives the operand and carry-in inputs of the combinational

---
 rtl/cla_accumulator_stage_if.sv | 44 ++++
 rtl/cla_accumulator_stage.sv | 106 ++++++++++
 tb/tb_cla_accumulator_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cla_accumulator_stage_if.sv
// rtl/cla_accumulator_stage_if.sv - input beat stream, result stream and adder hookup bundle
interface cla_accumulator_stage_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    // Accumulator side: consumes beats, drives the adder operands, produces results.
    modport slave (
        input  in_valid, in_data, in_sub, in_last,
        input  add_sum, add_cout,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_cin,
        output out_valid, out_data, out_carry, out_ovf, out_count
    );

    // Environment side: beat source, adder and result sink.
    modport master (
        output in_valid, in_data, in_sub, in_last,
        output add_sum, add_cout,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_cin,
        input  out_valid, out_data, out_carry, out_ovf, out_count
    );
endinterface

// File: rtl/cla_accumulator_stage.sv
// rtl/cla_accumulator_stage.sv - packet accumulator around an external carry-lookahead adder
module cla_accumulator_stage #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    cla_accumulator_stage_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    // The adder is built from 4-bit lookahead groups.
    if (WIDTH % 4 != 0) begin : g_width_check
        $error("cla_accumulator_stage: WIDTH must be a multiple of 4");
    end

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             beat_ovf;

    // Adder drive, handshakes and next-state for accumulation and result hand-off.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        carry_d       = carry_q;
        ovf_d         = ovf_q;
        count_d       = count_q;
        bus.add_a     = acc_q;
        bus.add_b     = '0;
        bus.add_cin   = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        beat_ovf      = 1'b0;

        case (state_q)
            ST_ACC: begin
                bus.in_ready = 1'b1;
                // Subtraction is acc + ~data + 1, so the adder never needs a mode pin.
                bus.add_b    = bus.in_sub ? ~bus.in_data : bus.in_data;
                bus.add_cin  = bus.in_sub;
                accept       = bus.in_valid;
                beat_ovf     = (bus.add_a[MSB] == bus.add_b[MSB]) &&
                               (bus.add_sum[MSB] != bus.add_a[MSB]);
                if (accept) begin
                    acc_d   = bus.add_sum;
                    // Carry-out of the subtract form is the inverse of a borrow.
                    carry_d = carry_q | (bus.in_sub ? ~bus.add_cout : bus.add_cout);
                    ovf_d   = ovf_q | beat_ovf;
                    count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                    if (bus.in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // Result registers double as the accumulator, so they hold steady through HOLD.
    always_comb begin
        bus.out_data  = acc_q;
        bus.out_carry = carry_q;
        bus.out_ovf   = ovf_q;
        bus.out_count = count_q;
    end

    // State and accumulator registers; reset discards any partial packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_cla_accumulator_stage.sv
// tb/tb_cla_accumulator_stage.sv - randomized and directed checks against a packet-level model
module tb_cla_accumulator_stage;
    localparam int WIDTH = 64;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    cla_accumulator_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    cla_accumulator_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational adder stand-in.
    logic [WIDTH:0] add_full;
    assign add_full     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + (WIDTH+1)'(bus.add_cin);
    assign bus.add_sum  = add_full[WIDTH-1:0];
    assign bus.add_cout = add_full[WIDTH];

    // Current packet contents.
    logic [WIDTH-1:0] q_data[$];
    bit               q_sub[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Packet-level reference: integer arithmetic, unsigned borrow and signed range tests.
    task automatic model(output logic [63:0] m_data, output logic m_carry,
                         output logic m_ovf, output logic [63:0] m_count);
        logic [63:0]        acc;
        logic               c, v;
        logic signed [64:0] s;
        logic signed [64:0] smax, smin;
        logic [64:0]        u;
        smax = 65'sh0_7FFF_FFFF_FFFF_FFFF;
        smin = -smax - 65'sd1;
        acc = '0; c = 1'b0; v = 1'b0;
        foreach (q_data[i]) begin
            if (q_sub[i]) begin
                if (q_data[i] > acc) c = 1'b1;
                s = $signed({acc[63], acc}) - $signed({q_data[i][63], q_data[i]});
                acc = acc - q_data[i];
            end else begin
                u = {1'b0, acc} + {1'b0, q_data[i]};
                if (u[64]) c = 1'b1;
                s = $signed({acc[63], acc}) + $signed({q_data[i][63], q_data[i]});
                acc = acc + q_data[i];
            end
            if (s > smax || s < smin) v = 1'b1;
        end
        m_data  = acc;
        m_carry = c;
        m_ovf   = v;
        m_count = (q_data.size() > 255) ? 64'd255 : 64'(q_data.size());
    endtask

    task automatic drive_beat(input logic [63:0] d, input bit sub, input bit last, input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sub   = sub;
        bus.in_last  = last;
    endtask

    // Sends the queued packet, checks the result one cycle after the last beat,
    // stalls the sink for hold_cycles (offering junk input meanwhile), then completes.
    task automatic send_packet(input string tag, input int hold_cycles, input bit gaps);
        logic [63:0] e_data, e_count;
        logic        e_carry, e_ovf;
        int          n;
        model(e_data, e_carry, e_ovf, e_count);
        n = q_data.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = {$urandom, $urandom};
                bus.in_last  = 1'b1;
            end
            drive_beat(q_data[i], q_sub[i], i == n - 1, tag);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"},      bus.out_data,       e_data);
        check({tag, "_carry"},     64'(bus.out_carry), 64'(e_carry));
        check({tag, "_ovf"},       64'(bus.out_ovf),   64'(e_ovf));
        check({tag, "_count"},     64'(bus.out_count), e_count);
        for (int h = 0; h < hold_cycles; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            bus.in_sub   = 1'($urandom);
            bus.in_last  = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(bus.in_ready),  64'd0);
            check({tag, "_hold_data"},  bus.out_data,       e_data);
            check({tag, "_hold_count"}, 64'(bus.out_count), e_count);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_done_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(bus.in_ready),  64'd1);
        check({tag, "_done_acc"},   bus.add_a,          64'd0);
        q_data.delete();
        q_sub.delete();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sub    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset takes effect without a clock edge.
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_add_a",     bus.add_a,          64'd0);
        check("rst_count",     64'(bus.out_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 5 + 7 + 10 back-to-back.
        q_data = '{64'd5, 64'd7, 64'd10}; q_sub = '{0, 0, 0};
        send_packet("sum3", 0, 0);
        check("sum3_lit", 64'd0, 64'd0 + bus.add_a);

        // 5 - 7 borrows.
        q_data = '{64'd5, 64'd7}; q_sub = '{0, 1};
        send_packet("borrow", 0, 0);

        // Signed overflow, then unsigned wrap to zero.
        q_data = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1}; q_sub = '{0, 0};
        send_packet("ovf", 0, 0);
        q_data = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1}; q_sub = '{0, 0};
        send_packet("wrap", 0, 0);

        // Stall the sink for five cycles, then a fresh single-beat packet.
        q_data = '{64'd3, 64'd4}; q_sub = '{0, 0};
        send_packet("stall", 5, 0);
        q_data = '{64'd9}; q_sub = '{0};
        send_packet("after_stall", 0, 0);

        // Asynchronous reset after two of three beats.
        drive_beat(64'd11, 1'b0, 1'b0, "rstmid");
        drive_beat(64'd12, 1'b0, 1'b0, "rstmid");
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstmid_acc",   bus.add_a,          64'd0);
        check("rstmid_count", 64'(bus.out_count), 64'd0);
        check("rstmid_valid", 64'(bus.out_valid), 64'd0);
        #1 rst = 1'b0;
        q_data = '{64'd4}; q_sub = '{0};
        send_packet("after_rst", 0, 0);

        // Randomized packets with idle gaps and sink stalls.
        for (int p = 0; p < 10; p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                q_data.push_back({$urandom, $urandom});
                q_sub.push_back(bit'($urandom));
            end
            send_packet($sformatf("rand%0d", p), int'($urandom_range(0, 3)), 1);
        end

        // Beat counter saturates rather than wrapping.
        for (int b = 0; b < 300; b++) begin
            q_data.push_back(64'(b + 1));
            q_sub.push_back(bit'(b % 3 == 0));
        end
        send_packet("sat", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
